alu_iter: RTL and testbench
===========================

Name: alu_iter

Overview:
- Next-generation ALU for the 16-bit CPU datapath.
- Width is parametrised (default 16), and the opcode set is extended with multi-bit shifts and a multiply.
- Operands and opcode are accepted through a valid/ready handshake. The result and the flags (Carry, isZero, Neg, Ovf) are held in registers until the consumer takes them.
- Shifts run one bit per cycle and multiply runs shift-add, so the block sits between decode/regfile read and writeback as a variable-latency execution unit.

Parameters:
- WIDTH, 16, operand/result width; must be a power of two, >= 8.
- CODE_W, 4, opcode width.
- SH_W, $clog2(WIDTH), shift-amount width taken from B[SH_W-1:0].

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  A/B/ALU_Code valid.
- in_ready  out  1  block can accept (high only in IDLE).
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; for shifts, B[SH_W-1:0] is the shift amount.
- ALU_Code  in  CODE_W  opcode.
- out_valid  out  1  result/flags valid (high only in DONE).
- out_ready  in  1  consumer accepts the result.
- ALU_Out  out  WIDTH  registered result.
- Carry  out  1  carry/borrow/shift-out/mul-high flag.
- isZero  out  1  ALU_Out == 0.
- Neg  out  1  ALU_Out[WIDTH-1].
- Ovf  out  1  signed overflow (ADD/SUB only).
- Err  out  1  illegal opcode.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge:
  - state = IDLE.
  - ALU_Out, Carry, isZero, Neg, Ovf, Err and out_valid = 0.
  - in_ready = 1 after the edge.
  - Reset overrides any in-flight operation, including mid-MUL or mid-shift; the partial result is discarded.
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A.
  - 6 SHL, 7 SHR (logical), 8 SAR (arithmetic).
  - 9 MUL (unsigned, low WIDTH bits to ALU_Out).
  - 10-15 illegal.
- States:
  - IDLE -> (accept, single-cycle or illegal op, or shift with amount 0) -> DONE.
  - IDLE -> (accept, shift with amount k>=1, or MUL) -> EXEC.
  - EXEC -> (last iteration) -> DONE.
  - DONE -> (out_ready) -> IDLE.
- Accept = in_valid & in_ready at a clk edge. A, B and ALU_Code are captured at that edge; later input changes have no effect.
- Latency, measured from the accept edge to out_valid high:
  - Single-cycle ops, illegal ops and shift-by-0: 1 cycle.
  - Shift by k: 1+k cycles.
  - MUL: 1+WIDTH cycles.
- EXEC does one shift step, or one shift-add step, per cycle using an internal down-counter.
- DONE holds ALU_Out and all flags stable until out_ready=1 is sampled; they return to IDLE on that edge. in_ready is low in DONE, so there is no same-edge re-accept. The next accept happens at the earliest one cycle later.
- Outputs keep their last values in IDLE and EXEC. out_valid is the only qualifier.
- Flags are computed from the final WIDTH-bit result:
  - isZero = (ALU_Out==0).
  - Neg = MSB.
  - ADD: Carry = carry out; Ovf = signed overflow.
  - SUB: Carry = borrow (1 iff A<B unsigned); Ovf = signed overflow.
  - AND/OR/XOR/NOT: Carry = 0, Ovf = 0.
  - Shifts: Carry = last bit shifted out (0 for shift-by-0); Ovf = 0.
  - MUL: Carry = 1 iff the high WIDTH bits of the 2*WIDTH product are nonzero; Ovf = 0.
- SAR replicates the MSB. SHL/SHR fill with 0.
- Illegal opcode: ALU_Out = 0, isZero = 1, other flags 0, Err = 1.
- Err = 0 for legal opcodes. Err is updated with every result.
- All arithmetic wraps modulo 2^WIDTH.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (OP_ADD..OP_MUL).
  - state encoding (S_IDLE, S_EXEC, S_DONE).
  - flag bit indices.
- One natural sub-module: alu_comb, the single-cycle combinational core (ADD..NOT with carry/overflow). alu_iter instantiates it and adds the FSM, shifter/multiplier datapath and output registers.

Test Plan (WIDTH=16):
- ADD A=0xFFFF B=0x0001, out_ready=1 -> out_valid 1 cycle after accept; ALU_Out=0x0000, Carry=1, isZero=1, Ovf=0; in_ready back high the cycle after.
- SUB A=0x0003 B=0x0005 -> ALU_Out=0xFFFE, Carry=1, Neg=1, Ovf=0. Then SUB A=0x8000 B=0x0001 -> 0x7FFF, Ovf=1, Carry=0.
- SHL A=0x8001 B=3 -> out_valid 4 cycles after accept; ALU_Out=0x0008, Carry=0. SAR A=0x8000 B=15 -> 0xFFFF, Neg=1. SHR by 0 -> latency 1, Carry=0.
- MUL A=0x0100 B=0x0101 -> out_valid 17 cycles after accept; ALU_Out=0x0100, Carry=1. MUL A=0x00FF B=0x00FF -> 0xFE01, Carry=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> ALU_Out/flags stable and in_ready=0 throughout; a new in_valid is not accepted until the cycle after out_ready=1. Also: ALU_Code=12 -> Err=1, ALU_Out=0, isZero=1.
- Reset mid-MUL: assert rst at cycle 8 of EXEC -> next cycle state IDLE, out_valid=0, all outputs 0, in_ready=1; a following ADD 2+3 returns 0x0005 normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU.
// Opcodes, FSM state encoding and flag-vector bit positions.
package alu_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_NOT = 5;
  localparam int OP_SHL = 6;
  localparam int OP_SHR = 7;
  localparam int OP_SAR = 8;
  localparam int OP_MUL = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;
  localparam int FLG_E = 4;
  localparam int FLG_W = 5;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle combinational core: ADD..NOT with carry and overflow.
// o_legal marks opcodes this core fully handles.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int CODE_W = 4
) (
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic [CODE_W-1:0] i_op,
  output logic [WIDTH-1:0]  o_y,
  output logic              o_c,
  output logic              o_v,
  output logic              o_legal
);

  localparam int M = WIDTH - 1;

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_dif;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  // The extra top bit of the difference is the borrow (a < b unsigned).
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};

  // Select the result and arithmetic flags for the simple opcodes.
  always_comb begin
    o_y     = '0;
    o_c     = 1'b0;
    o_v     = 1'b0;
    o_legal = 1'b1;
    unique case (i_op)
      CODE_W'(OP_ADD): begin
        o_y = w_sum[M:0];
        o_c = w_sum[WIDTH];
        o_v = (i_a[M] == i_b[M]) && (w_sum[M] != i_a[M]);
      end
      CODE_W'(OP_SUB): begin
        o_y = w_dif[M:0];
        o_c = w_dif[WIDTH];
        o_v = (i_a[M] != i_b[M]) && (w_dif[M] != i_a[M]);
      end
      CODE_W'(OP_AND): o_y = i_a & i_b;
      CODE_W'(OP_OR):  o_y = i_a | i_b;
      CODE_W'(OP_XOR): o_y = i_a ^ i_b;
      CODE_W'(OP_NOT): o_y = ~i_a;
      default:         o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Variable-latency ALU with valid/ready handshake.
// Shifts take one bit per cycle, MUL is WIDTH shift-add steps.
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int CODE_W = 4,
  parameter int SH_W   = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [CODE_W-1:0] ALU_Code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  ALU_Out,
  output logic              Carry,
  output logic              isZero,
  output logic              Neg,
  output logic              Ovf,
  output logic              Err
);

  localparam int M = WIDTH - 1;

  state_t r_state;
  state_t w_state_nxt;

  logic [CODE_W-1:0]  r_op;
  logic [WIDTH-1:0]   r_sh;
  logic [2*WIDTH-1:0] r_prod;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [SH_W-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_out;
  logic [FLG_W-1:0]   r_flags;

  logic               w_accept;
  logic [SH_W-1:0]    w_sh_amt;
  logic               w_in_shift;
  logic               w_in_mul;
  logic               w_go_exec;
  logic               w_last;
  logic               w_mul_r;
  logic [WIDTH-1:0]   w_comb_y;
  logic               w_comb_c;
  logic               w_comb_v;
  logic               w_comb_legal;
  logic [WIDTH-1:0]   w_sh_nxt;
  logic               w_sh_bit;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic               w_load;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic               w_e;
  logic [FLG_W-1:0]   w_flags;

  alu_comb #(
    .WIDTH  (WIDTH),
    .CODE_W (CODE_W)
  ) u_comb (
    .i_a     (A),
    .i_b     (B),
    .i_op    (ALU_Code),
    .o_y     (w_comb_y),
    .o_c     (w_comb_c),
    .o_v     (w_comb_v),
    .o_legal (w_comb_legal)
  );

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign w_accept   = in_valid & in_ready;
  assign w_sh_amt   = B[SH_W-1:0];
  assign w_in_shift = (ALU_Code == CODE_W'(OP_SHL))
                    | (ALU_Code == CODE_W'(OP_SHR))
                    | (ALU_Code == CODE_W'(OP_SAR));
  assign w_in_mul   = (ALU_Code == CODE_W'(OP_MUL));
  assign w_go_exec  = (w_in_shift && (w_sh_amt != '0)) || w_in_mul;
  assign w_last     = (r_cnt == '0);
  assign w_mul_r    = (r_op == CODE_W'(OP_MUL));
  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept)
                w_state_nxt = w_go_exec ? S_EXEC : S_DONE;
      S_EXEC: if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One-bit shift step; the bit leaving the word becomes Carry.
  always_comb begin
    w_sh_nxt = r_sh;
    w_sh_bit = 1'b0;
    unique case (r_op)
      CODE_W'(OP_SHL): begin
        w_sh_bit = r_sh[M];
        w_sh_nxt = {r_sh[M-1:0], 1'b0};
      end
      CODE_W'(OP_SHR): begin
        w_sh_bit = r_sh[0];
        w_sh_nxt = {1'b0, r_sh[M:1]};
      end
      CODE_W'(OP_SAR): begin
        w_sh_bit = r_sh[0];
        w_sh_nxt = {r_sh[M], r_sh[M:1]};
      end
      default: ;
    endcase
  end

  // Pick the result to latch into the output registers, if any.
  always_comb begin
    w_load = 1'b0;
    w_res  = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    w_e    = 1'b0;
    if (w_accept) begin
      if (w_comb_legal) begin
        w_load = 1'b1;
        w_res  = w_comb_y;
        w_c    = w_comb_c;
        w_v    = w_comb_v;
      end else if (w_in_shift && (w_sh_amt == '0)) begin
        w_load = 1'b1;
        w_res  = A;
      end else if (!w_in_shift && !w_in_mul) begin
        w_load = 1'b1;
        w_e    = 1'b1;
      end
    end else if ((r_state == S_EXEC) && w_last) begin
      w_load = 1'b1;
      if (w_mul_r) begin
        w_res = w_prod_nxt[M:0];
        w_c   = |w_prod_nxt[2*WIDTH-1:WIDTH];
      end else begin
        w_res = w_sh_nxt;
        w_c   = w_sh_bit;
      end
    end
  end

  // Zero/negative flags always follow the value being latched.
  always_comb begin
    w_flags        = '0;
    w_flags[FLG_C] = w_c;
    w_flags[FLG_Z] = (w_res == '0);
    w_flags[FLG_N] = w_res[M];
    w_flags[FLG_V] = w_v;
    w_flags[FLG_E] = w_e;
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= '0;
      r_sh     <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_flags  <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= ALU_Code;
        r_sh     <= A;
        r_prod   <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, A};
        r_mplier <= B;
        r_cnt    <= w_in_mul ? SH_W'(WIDTH - 1)
                             : w_sh_amt - SH_W'(1);
      end else if (r_state == S_EXEC) begin
        r_sh     <= w_sh_nxt;
        r_prod   <= w_prod_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - SH_W'(1);
      end
      if (w_load) begin
        r_out   <= w_res;
        r_flags <= w_flags;
      end
    end
  end

  assign ALU_Out = r_out;
  assign Carry   = r_flags[FLG_C];
  assign isZero  = r_flags[FLG_Z];
  assign Neg     = r_flags[FLG_N];
  assign Ovf     = r_flags[FLG_V];
  assign Err     = r_flags[FLG_E];

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter at WIDTH=16.
// Observation vector is {ALU_Out, C, Z, N, V, E}.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  ALU_Code;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] ALU_Out;
  logic        Carry;
  logic        isZero;
  logic        Neg;
  logic        Ovf;
  logic        Err;

  int nvec = 0;
  int nerr = 0;

  alu_iter #(.WIDTH(16), .CODE_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALU_Code  (ALU_Code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_Out   (ALU_Out),
    .Carry     (Carry),
    .isZero    (isZero),
    .Neg       (Neg),
    .Ovf       (Ovf),
    .Err       (Err)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] obs();
    return {ALU_Out, Carry, isZero, Neg, Ovf, Err};
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op, input logic ordy);
    @(negedge clk);
    A = a;
    B = b;
    ALU_Code = op;
    out_ready = ordy;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    ALU_Code = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    nvec++;
    if ({in_ready, out_valid, obs()} !== {2'b10, 21'h0}) begin
      nerr++;
      $display("FAIL reset got rdy/vld/obs=%b/%b/%h exp 1/0/000000",
               in_ready, out_valid, obs());
    end
    lat = 0;
  endtask

  task automatic test_add();
    int lat;
    issue(16'hFFFF, 16'h0001, 4'd0, 1'b1);
    wait_done(lat);
    nvec++;
    if (lat !== 1) begin
      nerr++;
      $display("FAIL add_lat got %0d exp 1", lat);
    end
    nvec++;
    if (obs() !== {16'h0000, 5'b11000}) begin
      nerr++;
      $display("FAIL add got %h exp %h", obs(), {16'h0000, 5'b11000});
    end
    @(negedge clk);
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL add_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_sub();
    int lat;
    issue(16'h0003, 16'h0005, 4'd1, 1'b1);
    wait_done(lat);
    nvec++;
    if ({lat[7:0], obs()} !== {8'd1, 16'hFFFE, 5'b10100}) begin
      nerr++;
      $display("FAIL sub1 got lat %0d %h exp lat 1 %h",
               lat, obs(), {16'hFFFE, 5'b10100});
    end
    issue(16'h8000, 16'h0001, 4'd1, 1'b1);
    wait_done(lat);
    nvec++;
    if ({lat[7:0], obs()} !== {8'd1, 16'h7FFF, 5'b00010}) begin
      nerr++;
      $display("FAIL sub2 got lat %0d %h exp lat 1 %h",
               lat, obs(), {16'h7FFF, 5'b00010});
    end
  endtask

  task automatic test_logic();
    int lat;
    issue(16'hF0F0, 16'h0FF0, 4'd4, 1'b1);
    wait_done(lat);
    nvec++;
    if ({lat[7:0], obs()} !== {8'd1, 16'hFF00, 5'b00100}) begin
      nerr++;
      $display("FAIL xor got lat %0d %h exp lat 1 %h",
               lat, obs(), {16'hFF00, 5'b00100});
    end
    issue(16'hFFFF, 16'h1234, 4'd5, 1'b1);
    wait_done(lat);
    nvec++;
    if ({lat[7:0], obs()} !== {8'd1, 16'h0000, 5'b01000}) begin
      nerr++;
      $display("FAIL not got lat %0d %h exp lat 1 %h",
               lat, obs(), {16'h0000, 5'b01000});
    end
  endtask

  task automatic test_shift();
    int lat;
    issue(16'h8001, 16'h0003, 4'd6, 1'b1);
    wait_done(lat);
    nvec++;
    if ({lat[7:0], obs()} !== {8'd4, 16'h0008, 5'b00000}) begin
      nerr++;
      $display("FAIL shl3 got lat %0d %h exp lat 4 %h",
               lat, obs(), {16'h0008, 5'b00000});
    end
    issue(16'h8000, 16'h000F, 4'd8, 1'b1);
    wait_done(lat);
    nvec++;
    if ({lat[7:0], obs()} !== {8'd16, 16'hFFFF, 5'b00100}) begin
      nerr++;
      $display("FAIL sar15 got lat %0d %h exp lat 16 %h",
               lat, obs(), {16'hFFFF, 5'b00100});
    end
    issue(16'h1234, 16'h0010, 4'd7, 1'b1);
    wait_done(lat);
    nvec++;
    if ({lat[7:0], obs()} !== {8'd1, 16'h1234, 5'b00000}) begin
      nerr++;
      $display("FAIL shr0 got lat %0d %h exp lat 1 %h",
               lat, obs(), {16'h1234, 5'b00000});
    end
    issue(16'h0003, 16'h0001, 4'd7, 1'b1);
    wait_done(lat);
    nvec++;
    if ({lat[7:0], obs()} !== {8'd2, 16'h0001, 5'b10000}) begin
      nerr++;
      $display("FAIL shr1 got lat %0d %h exp lat 2 %h",
               lat, obs(), {16'h0001, 5'b10000});
    end
  endtask

  task automatic test_mul();
    int lat;
    issue(16'h0100, 16'h0101, 4'd9, 1'b1);
    wait_done(lat);
    nvec++;
    if ({lat[7:0], obs()} !== {8'd17, 16'h0100, 5'b10000}) begin
      nerr++;
      $display("FAIL mul1 got lat %0d %h exp lat 17 %h",
               lat, obs(), {16'h0100, 5'b10000});
    end
    issue(16'h00FF, 16'h00FF, 4'd9, 1'b1);
    wait_done(lat);
    nvec++;
    if ({lat[7:0], obs()} !== {8'd17, 16'hFE01, 5'b00100}) begin
      nerr++;
      $display("FAIL mul2 got lat %0d %h exp lat 17 %h",
               lat, obs(), {16'hFE01, 5'b00100});
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(16'h1234, 16'h1111, 4'd0, 1'b0);
    wait_done(lat);
    nvec++;
    if ({lat[7:0], obs()} !== {8'd1, 16'h2345, 5'b00000}) begin
      nerr++;
      $display("FAIL bp_first got lat %0d %h exp lat 1 %h",
               lat, obs(), {16'h2345, 5'b00000});
    end
    A = 16'h0001;
    B = 16'h0001;
    ALU_Code = 4'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nvec++;
      if ({out_valid, in_ready, obs()} !== {2'b10, 16'h2345, 5'b00000}) begin
        nerr++;
        $display("FAIL bp_hold%0d got vld/rdy/obs %b/%b/%h exp 1/0/%h",
                 i, out_valid, in_ready, obs(), {16'h2345, 5'b00000});
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    nvec++;
    if ({out_valid, in_ready, obs()} !== {2'b01, 16'h2345, 5'b00000}) begin
      nerr++;
      $display("FAIL bp_idle got vld/rdy/obs %b/%b/%h exp 0/1/%h",
               out_valid, in_ready, obs(), {16'h2345, 5'b00000});
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(lat);
    nvec++;
    if ({lat[7:0], obs()} !== {8'd1, 16'h0002, 5'b00000}) begin
      nerr++;
      $display("FAIL bp_next got lat %0d %h exp lat 1 %h",
               lat, obs(), {16'h0002, 5'b00000});
    end
  endtask

  task automatic test_illegal();
    int lat;
    issue(16'h0005, 16'h0007, 4'd12, 1'b1);
    wait_done(lat);
    nvec++;
    if ({lat[7:0], obs()} !== {8'd1, 16'h0000, 5'b01001}) begin
      nerr++;
      $display("FAIL illegal got lat %0d %h exp lat 1 %h",
               lat, obs(), {16'h0000, 5'b01001});
    end
    issue(16'h0005, 16'h0007, 4'd2, 1'b1);
    wait_done(lat);
    nvec++;
    if ({lat[7:0], obs()} !== {8'd1, 16'h0005, 5'b00000}) begin
      nerr++;
      $display("FAIL err_clear got lat %0d %h exp lat 1 %h",
               lat, obs(), {16'h0005, 5'b00000});
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    issue(16'hFFFF, 16'hFFFF, 4'd9, 1'b1);
    for (int k = 1; k <= 8; k++) @(negedge clk);
    nvec++;
    if ({out_valid, in_ready} !== 2'b00) begin
      nerr++;
      $display("FAIL mid_mul got vld/rdy %b/%b exp 0/0",
               out_valid, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    nvec++;
    if ({in_ready, out_valid, obs()} !== {2'b10, 21'h0}) begin
      nerr++;
      $display("FAIL rst_mul got rdy/vld/obs %b/%b/%h exp 1/0/000000",
               in_ready, out_valid, obs());
    end
    rst = 1'b0;
    issue(16'h0002, 16'h0003, 4'd0, 1'b1);
    wait_done(lat);
    nvec++;
    if ({lat[7:0], obs()} !== {8'd1, 16'h0005, 5'b00000}) begin
      nerr++;
      $display("FAIL post_rst got lat %0d %h exp lat 1 %h",
               lat, obs(), {16'h0005, 5'b00000});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_mul();
    test_back_to_back();
    test_illegal();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
